// File: rtl/weight_pattern_gen_pkg.sv
// Shared types and helpers for the weight pattern generator: default width,
// FSM encoding and the final (top-aligned) pattern of a weight-k run.
package weight_pattern_pkg;
    localparam int W_DEF = 8;
    localparam int W_MAX = 16;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EMIT = 2'd1,
        S_FIN  = 2'd2
    } state_e;

    // ((1<<k)-1) << (w-k): the k ones packed against the MSB of a w-bit word
    function automatic logic [W_MAX-1:0] final_pattern(input int w, input int k);
        logic [W_MAX-1:0] f;
        for (int i = 0; i < W_MAX; i++) begin
            f[i] = (i < w) && (i >= w - k);
        end
        return f;
    endfunction
endpackage

// File: rtl/weight_pattern_gen_if.sv
// Start/weight request and valid/ready pattern stream of the generator.
interface weight_pattern_gen_if #(
    parameter int W  = weight_pattern_pkg::W_DEF,
    parameter int KW = $clog2(W + 1)
) ();
    logic          start;
    logic [KW-1:0] weight;
    logic          busy;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  pattern;
    logic          last;
    logic [W-1:0]  count;
    logic          done;
    logic          err;

    modport master (
        input  start, weight, out_ready,
        output busy, out_valid, pattern, last, count, done, err
    );

    modport slave (
        output start, weight, out_ready,
        input  busy, out_valid, pattern, last, count, done, err
    );
endinterface

// File: rtl/weight_pattern_gen_gosper.sv
// Combinational Gosper step: smallest word above x with the same popcount.
// Evaluated in W+1 bits; never applied to the final pattern of a run.
module gosper_next #(
    parameter int W = 8
) (
    input  logic [W-1:0] x,
    output logic [W-1:0] nxt
);
    localparam int TW = $clog2(W);

    logic [W:0]    xe, c, r, sh, res;
    logic [TW-1:0] tz;
    logic          unused_msb;

    always_comb begin
        xe = {1'b0, x};
        c  = xe & (~xe + 1'b1);
        r  = xe + c;
        // c is one-hot, so this priority encoder is simply its bit index
        tz = '0;
        for (int i = W - 1; i >= 0; i--) begin
            if (c[i]) tz = TW'(i);
        end
        sh  = ((xe ^ r) >> 2) >> tz;
        res = r | sh;
        nxt = res[W-1:0];
    end

    assign unused_msb = res[W] ^ c[W];
endmodule

// File: rtl/weight_pattern_gen.sv
// Emits every W-bit word of popcount k in ascending order over a valid/ready
// stream; a k>W request is rejected with a done/err pulse.
module weight_pattern_gen
    import weight_pattern_pkg::*;
#(
    parameter int W = W_DEF
) (
    input logic                 clk,
    input logic                 rst_n,
    weight_pattern_gen_if.master io
);
    state_e       state_q, state_d;
    logic [W-1:0] pat_q, pat_d, fin_q, fin_d, cnt_q, cnt_d;
    logic         last_q, last_d, busy_q, busy_d, vld_q, vld_d;
    logic         done_q, done_d, err_q, err_d;

    logic [W-1:0]     first_w, fin_w, nxt_w;
    logic [W_MAX-1:0] fin_full;
    logic             unused_fin;

    gosper_next #(.W(W)) u_next (.x(pat_q), .nxt(nxt_w));

    always_comb begin
        for (int i = 0; i < W; i++) first_w[i] = (i < int'(io.weight));
        fin_full = final_pattern(W, int'(io.weight));
        fin_w    = fin_full[W-1:0];
    end
    assign unused_fin = ^fin_full;

    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        fin_d   = fin_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        busy_d  = busy_q;
        vld_d   = vld_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: if (io.start) begin
                cnt_d = '0;
                if (int'(io.weight) > W) begin
                    state_d = S_FIN;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end else begin
                    state_d = S_EMIT;
                    pat_d   = first_w;
                    fin_d   = fin_w;
                    last_d  = (first_w == fin_w);
                    vld_d   = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            S_EMIT: if (io.out_ready) begin
                cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
                if (last_q) begin
                    state_d = S_FIN;
                    last_d  = 1'b0;
                    vld_d   = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    pat_d  = nxt_w;
                    last_d = (nxt_w == fin_q);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pat_q   <= '0;
            fin_q   <= '0;
            cnt_q   <= '0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            vld_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            fin_q   <= fin_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            vld_q   <= vld_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign io.pattern   = pat_q;
    assign io.count     = cnt_q;
    assign io.last      = last_q;
    assign io.busy      = busy_q;
    assign io.out_valid = vld_q;
    assign io.done      = done_q;
    assign io.err       = err_q;
endmodule

// File: doc/weight_pattern_gen.md
# weight_pattern_gen

Sequential generator that takes a Hamming weight k and emits every W-bit word with exactly k ones, one word per accepted handshake, in ascending numeric order. It is the inverse of the datapath's combinational popcount unit: popcount maps word to weight, and this block maps weight to all matching words. It serves as a test-vector and mask source for the ALU bit-count path and is driven by the control/test sequencer over a start pulse and a valid/ready output stream.

## Interface
- W, 8, pattern width in bits; legal range 2..16.
- KW, $clog2(W+1), width of the weight field.
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset: synchronous, active-low.
- start  in  1  one-cycle request; sampled only in IDLE.
- weight  in  KW  requested weight k; sampled with start.
- busy  out  1  high from the cycle after an accepted start until the final handshake.
- out_valid  out  1  pattern is valid.
- out_ready  in  1  consumer accepts the pattern when out_valid && out_ready.
- pattern  out  W  current word.
- last  out  1  high with the final pattern of the sequence.
- count  out  W  number of patterns accepted so far in this run; saturates at 2^W-1.
- done  out  1  one-cycle pulse after the final handshake or after a rejected start.
- err  out  1  one-cycle pulse, coincident with done, when k > W.

## Operation
- States:
  - S_IDLE: waits for start.
  - S_EMIT: presents a pattern and waits for the handshake.
  - S_FIN: lasts one cycle and drives done.
- Reset values: the state is S_IDLE, and all outputs are 0 (pattern=0, count=0, busy=0, out_valid=0, last=0, done=0, err=0).
- S_IDLE with start=1:
  - k>W: go to S_FIN with err=1. No pattern is emitted.
  - k=0: pattern=0 and last=1. Go to S_EMIT.
  - 1≤k≤W: pattern=(1<<k)-1. last=1 only if k=W. Go to S_EMIT.
  - count is cleared to 0 in all three cases.
- S_IDLE with start=0: stay in S_IDLE. A start seen in S_EMIT or S_FIN is ignored and not queued.
- S_EMIT:
  - out_valid=1, and pattern and last are held stable until the handshake.
  - On a handshake with last=1: go to S_FIN and increment count.
  - On a handshake with last=0: pattern is loaded with next(pattern) and count is incremented.
  - last is registered as (next == ((1<<k)-1) << (W-k)).
- next(x) is Gosper's step, computed in W+1 bits:
  - c = x & -x
  - r = x + c
  - next = r | (((x ^ r) >> 2) >> ctz(c))
  - ctz comes from a W-input priority encoder; no divider is used.
  - Overflow cannot occur because the final pattern is never advanced.
- S_FIN: done=1 for one cycle, then go to S_IDLE.
- Run length is C(W,k) patterns, for example C(8,4)=70.
- rst_n low in any state returns the block to S_IDLE with reset values on the next edge. A partial run is discarded.

## Timing
- start accepted at edge t: out_valid=1 from edge t+1.
- With out_ready held high, one pattern per cycle. The run of N patterns occupies cycles t+1..t+N, and done pulses in cycle t+N+1.
- The earliest next start is accepted at edge t+N+2 (the first S_IDLE cycle).
- Backpressure: with out_ready=0, pattern, last and count are held unchanged. out_valid never drops until the handshake.
- Rejected start (k>W): done=err=1 in cycle t+1. out_valid stays 0.
- Every output is registered and has no combinational path from an input.

## Structure
- Package weight_pattern_pkg holds:
  - the default W;
  - the state encoding (S_IDLE, S_EMIT, S_FIN);
  - a function giving the final pattern, ((1<<k)-1)<<(W-k).
- One sub-module, gosper_next: purely combinational x→next(x), parameterized by W and containing the ctz priority encoder. It is unit-testable on its own.
- The top level holds the FSM, the pattern, count and last registers, and the start decode.

## Test plan
- W=8, k=2, out_ready=1:
  - Required sequence: 0x03, 0x05, 0x06, 0x09, …, 0xA0, 0xC0.
  - Exactly 28 patterns, with last only on 0xC0 and count=28.
  - done pulses one cycle after the last handshake.
- W=8, k=4, out_ready=1:
  - 70 patterns, strictly ascending, no repeats.
  - A popcount checker confirms each pattern has weight 4.
  - The first pattern is 0x0F and the final one is 0xF0.
- Single-pattern runs:
  - k=0 gives a single pattern 0x00 with last=1, then done.
  - k=8 gives a single pattern 0xFF with last=1.
- Rejected start: k=9 gives done=err=1 in cycle t+1, out_valid never asserts, and busy stays 0.
- Backpressure and ignored start (k=3):
  - Drop out_ready for 3 cycles on the second pattern (0x0B). pattern, last and count stay stable, and the sequence resumes with 0x0D.
  - A start pulsed mid-run has no effect.
- Reset mid-run: assert rst_n=0 during k=5 after 10 patterns.
  - Next edge: S_IDLE with all outputs 0.
  - A fresh start with k=1 then yields 0x01, 0x02, …, 0x80.
